// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and full/empty flags.
// Storage is a one-write/one-read RAM array; the read port registers into o_data.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_fill
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FILL_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_en;
  logic                  rd_en;

  // Accept logic and next-state computation; a full FIFO still takes a write when a read frees a slot
  always_comb begin
    rd_en  = i_rd & ~empty_q;
    wr_en  = i_wr & (~full_q | rd_en);
    wptr_d = wr_en ? (wptr_q + ADDR_WIDTH'(1)) : wptr_q;
    rptr_d = rd_en ? (rptr_q + ADDR_WIDTH'(1)) : rptr_q;
    data_d = rd_en ? mem_q[rptr_q] : data_q;
    case ({wr_en, rd_en})
      2'b10:   fill_d = fill_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   fill_d = fill_q - (ADDR_WIDTH + 1)'(1);
      default: fill_d = fill_q;
    endcase
    full_d  = (fill_d == FILL_MAX);
    empty_d = (fill_d == {(ADDR_WIDTH + 1){1'b0}});
  end

  // Control state, flags and read data register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr_q  <= {ADDR_WIDTH{1'b0}};
      rptr_q  <= {ADDR_WIDTH{1'b0}};
      fill_q  <= {(ADDR_WIDTH + 1){1'b0}};
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fill_q  <= fill_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      data_q  <= data_d;
    end
  end

  // RAM write port, left unreset so it maps onto block memory
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= i_data;
    end
  end

  assign o_data  = data_q;
  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_fill  = fill_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized self-checking bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;

  logic        i_clk;
  logic        i_rstn;
  logic        i_wr;
  logic [31:0] i_data;
  logic        i_rd;
  logic [31:0] o_data;
  logic        o_full;
  logic        o_empty;
  logic [10:0] o_fill;

  logic [31:0] model_q[$];
  logic [31:0] exp_data;
  int          n_cmp;
  int          n_fail;

  sync_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_wr   (i_wr),
    .i_data (i_data),
    .i_rd   (i_rd),
    .o_data (o_data),
    .o_full (o_full),
    .o_empty(o_empty),
    .o_fill (o_fill)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Drive one cycle of requests, advance the model, return 1 ns after the edge.
  task automatic drive_cycle(input logic wr, input logic [31:0] d, input logic rd);
    bit rd_ok;
    bit wr_ok;
    i_wr   = wr;
    i_data = d;
    i_rd   = rd;
    rd_ok  = rd && (model_q.size() > 0);
    wr_ok  = wr && ((model_q.size() < 1024) || rd_ok);
    if (rd_ok) exp_data = model_q.pop_front();
    if (wr_ok) model_q.push_back(d);
    @(posedge i_clk);
    #1;
    i_wr = 1'b0;
    i_rd = 1'b0;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_data = 32'd0;
    model_q.delete(); exp_data = 32'd0;
    repeat (2) @(posedge i_clk);
    #1;
    n_cmp++;
    if (o_empty !== 1'b1 || o_full !== 1'b0 || o_fill !== 11'd0 || o_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: empty=%b full=%b fill=%0d data=%h, want 1 0 0 0", o_empty, o_full, o_fill, o_data);
    end
    @(negedge i_clk); i_rstn = 1'b1;
    @(posedge i_clk); #1;
    drive_cycle(1'b1, 32'h1111_1111, 1'b0);
    drive_cycle(1'b1, 32'h2222_2222, 1'b0);
    drive_cycle(1'b1, 32'h3333_3333, 1'b1);
    n_cmp++;
    if (o_data !== 32'h1111_1111 || o_fill !== 11'd2) begin
      n_fail++;
      $display("FAIL reset_prefill: data=%h fill=%0d, want 11111111 2", o_data, o_fill);
    end
    i_rstn = 1'b0;
    #1;
    n_cmp++;
    if (o_empty !== 1'b1 || o_full !== 1'b0 || o_fill !== 11'd0 || o_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_async: empty=%b full=%b fill=%0d data=%h, want 1 0 0 0", o_empty, o_full, o_fill, o_data);
    end
    model_q.delete(); exp_data = 32'd0;
    @(negedge i_clk); i_rstn = 1'b1;
    @(posedge i_clk); #1;
    drive_cycle(1'b0, 32'd0, 1'b1);
    n_cmp++;
    if (o_data !== 32'd0 || o_empty !== 1'b1 || o_fill !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_discard: data=%h empty=%b fill=%0d, want 0 1 0", o_data, o_empty, o_fill);
    end
  endtask

  task automatic test_single();
    drive_cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
    n_cmp++;
    if (o_fill !== 11'd1 || o_empty !== 1'b0 || o_full !== 1'b0) begin
      n_fail++;
      $display("FAIL single_write: fill=%0d empty=%b full=%b, want 1 0 0", o_fill, o_empty, o_full);
    end
    drive_cycle(1'b0, 32'd0, 1'b1);
    n_cmp++;
    if (o_data !== 32'hDEAD_BEEF || o_fill !== 11'd0 || o_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL single_read: data=%h fill=%0d empty=%b, want deadbeef 0 1", o_data, o_fill, o_empty);
    end
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < 1024; i++) begin
      drive_cycle(1'b1, 32'(i), 1'b0);
      n_cmp++;
      if (o_fill !== 11'(model_q.size()) || o_full !== (model_q.size() == 1024)) begin
        n_fail++;
        $display("FAIL fill_step%0d: fill=%0d full=%b, want %0d %b", i, o_fill, o_full, model_q.size(), model_q.size() == 1024);
      end
    end
    n_cmp++;
    if (o_full !== 1'b1 || o_fill !== 11'd1024 || o_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL full_flag: full=%b fill=%0d empty=%b, want 1 1024 0", o_full, o_fill, o_empty);
    end
    drive_cycle(1'b1, 32'hFFFF_FFFF, 1'b0);
    n_cmp++;
    if (o_full !== 1'b1 || o_fill !== 11'd1024 || o_data !== exp_data) begin
      n_fail++;
      $display("FAIL full_write_ignored: full=%b fill=%0d data=%h, want 1 1024 %h", o_full, o_fill, o_data, exp_data);
    end
    drive_cycle(1'b1, $urandom, 1'b1);
    n_cmp++;
    if (o_full !== 1'b1 || o_fill !== 11'd1024 || o_data !== 32'd0) begin
      n_fail++;
      $display("FAIL full_rdwr: full=%b fill=%0d data=%h, want 1 1024 0", o_full, o_fill, o_data);
    end
    for (int i = 0; i < 1100 && model_q.size() > 0; i++) begin
      drive_cycle(1'b0, 32'd0, 1'b1);
      n_cmp++;
      if (o_data !== exp_data || o_fill !== 11'(model_q.size())) begin
        n_fail++;
        $display("FAIL drain%0d: data=%h fill=%0d, want %h %0d", i, o_data, o_fill, exp_data, model_q.size());
      end
    end
    n_cmp++;
    if (o_empty !== 1'b1 || o_fill !== 11'd0 || o_full !== 1'b0) begin
      n_fail++;
      $display("FAIL drained_empty: empty=%b fill=%0d full=%b, want 1 0 0", o_empty, o_fill, o_full);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] held;
    held = o_data;
    drive_cycle(1'b0, 32'd0, 1'b1);
    n_cmp++;
    if (o_data !== held || o_fill !== 11'd0 || o_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_read: data=%h fill=%0d empty=%b, want %h 0 1", o_data, o_fill, o_empty, held);
    end
    drive_cycle(1'b1, 32'hA5A5_0001, 1'b1);
    n_cmp++;
    if (o_data !== held || o_fill !== 11'd1 || o_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_rdwr: data=%h fill=%0d empty=%b, want %h 1 0", o_data, o_fill, o_empty, held);
    end
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, $urandom, 1'b0);
    n_cmp++;
    if (o_fill !== 11'd5) begin
      n_fail++;
      $display("FAIL fill5_setup: fill=%0d, want 5", o_fill);
    end
    drive_cycle(1'b1, $urandom, 1'b1);
    n_cmp++;
    if (o_fill !== 11'd5 || o_data !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL fill5_rdwr: fill=%0d data=%h, want 5 a5a50001", o_fill, o_data);
    end
  endtask

  task automatic test_stream();
    int written;
    int cycles;
    bit wr;
    bit rd;
    written = 0;
    cycles  = 0;
    while (written < 3000 && cycles < 20000) begin
      wr = (model_q.size() < 10) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rd = (model_q.size() > 8) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 0);
      if (wr) written++;
      drive_cycle(wr, $urandom, rd);
      cycles++;
      n_cmp++;
      if (o_data !== exp_data || o_fill !== 11'(model_q.size()) ||
          o_empty !== (model_q.size() == 0) || o_full !== (model_q.size() == 1024)) begin
        n_fail++;
        $display("FAIL stream%0d: data=%h fill=%0d empty=%b full=%b, want %h %0d", cycles, o_data, o_fill, o_empty, o_full, exp_data, model_q.size());
      end
    end
    n_cmp++;
    if (written < 3000) begin
      n_fail++;
      $display("FAIL stream_budget: written=%0d, want 3000", written);
    end
    for (int i = 0; i < 2000 && model_q.size() > 0; i++) begin
      drive_cycle(1'b0, 32'd0, 1'b1);
      n_cmp++;
      if (o_data !== exp_data || o_fill !== 11'(model_q.size())) begin
        n_fail++;
        $display("FAIL stream_drain%0d: data=%h fill=%0d, want %h %0d", i, o_data, o_fill, exp_data, model_q.size());
      end
    end
    n_cmp++;
    if (o_empty !== 1'b1 || o_fill !== 11'd0) begin
      n_fail++;
      $display("FAIL stream_end: empty=%b fill=%0d, want 1 0", o_empty, o_fill);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_fill_full();
    test_boundaries();
    test_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
